// File: rtl/icache_line_responder_pkg.sv
// rtl/icache_line_responder_pkg.sv - shared widths and line geometry for the instruction-cache line responder
package icache_line_responder_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_OFFSET_W = 5;
  localparam int DEF_TAG_W    = 3;

  function automatic int words_for(input int offset_w);
    return 2 ** offset_w;
  endfunction

  localparam int LINE_WORDS = words_for(DEF_OFFSET_W);
  localparam int FILL_SAT   = LINE_WORDS;

endpackage

// File: rtl/icache_line_ram.sv
// rtl/icache_line_ram.sv - line storage, one write port, registered write-first read port, no reset
module icache_line_ram #(
  parameter int DATA_W   = 8,
  parameter int OFFSET_W = 5
) (
  input  logic                clk,
  input  logic                i_wr_en,
  input  logic [OFFSET_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [OFFSET_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0]   o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**OFFSET_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/icache_line_responder.sv
// rtl/icache_line_responder.sv - single-line icache fill/read responder: valid bits, tag, fill counting, sequence check
module icache_line_responder
  import icache_line_responder_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int TAG_W    = DEF_TAG_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cache_wren,
  input  logic [OFFSET_W-1:0] cache_wroffset,
  input  logic [DATA_W-1:0]   rom_data,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [OFFSET_W-1:0] cache_rdoffset,
  input  logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   instr,
  output logic                instr_valid,
  output logic                line_valid,
  output logic [TAG_W-1:0]    line_tag,
  output logic [OFFSET_W:0]   fill_count,
  output logic                fill_error
);

  localparam int                N_WORDS   = words_for(OFFSET_W);
  localparam logic [OFFSET_W:0] COUNT_SAT = (OFFSET_W+1)'(N_WORDS);

  logic                r_wren_d;
  logic [N_WORDS-1:0]  r_valid;
  logic [TAG_W-1:0]    r_line_tag;
  logic [OFFSET_W:0]   r_fill_count;
  logic [OFFSET_W-1:0] r_exp_offset;
  logic                r_fill_error;
  logic                r_line_valid;
  logic                r_instr_valid;
  logic                r_rd_live;

  logic                w_fill_start;
  logic [N_WORDS-1:0]  w_wr_mask;
  logic [N_WORDS-1:0]  w_valid_next;
  logic [TAG_W-1:0]    w_tag_next;
  logic [OFFSET_W-1:0] w_exp_offset;
  logic                w_seq_bad;
  logic [DATA_W-1:0]   w_ram_q;

  assign w_fill_start = cache_wren && !r_wren_d;
  assign w_wr_mask    = {{(N_WORDS-1){1'b0}}, 1'b1} << cache_wroffset;
  assign w_tag_next   = w_fill_start ? fill_tag : r_line_tag;
  assign w_exp_offset = w_fill_start ? '0 : r_exp_offset;
  assign w_seq_bad    = cache_wren && (cache_wroffset != w_exp_offset);

  // A fill start wipes every valid bit except the word being written this same cycle.
  always_comb begin
    w_valid_next = r_valid;
    if (w_fill_start) begin
      w_valid_next = w_wr_mask;
    end else if (cache_wren) begin
      w_valid_next = r_valid | w_wr_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wren_d      <= 1'b0;
      r_valid       <= '0;
      r_line_tag    <= '0;
      r_fill_count  <= '0;
      r_exp_offset  <= '0;
      r_fill_error  <= 1'b0;
      r_line_valid  <= 1'b0;
      r_instr_valid <= 1'b0;
      r_rd_live     <= 1'b0;
    end else begin
      r_wren_d      <= cache_wren;
      r_valid       <= w_valid_next;
      r_line_tag    <= w_tag_next;
      r_rd_live     <= 1'b1;
      r_instr_valid <= w_valid_next[cache_rdoffset] && (rd_tag == w_tag_next);
      if (w_seq_bad) begin
        r_fill_error <= 1'b1;
      end
      if (cache_wren) begin
        r_exp_offset <= cache_wroffset + 1'b1;
      end
      if (w_fill_start) begin
        r_fill_count <= (OFFSET_W+1)'(1);
      end else if (cache_wren && (r_fill_count < COUNT_SAT)) begin
        r_fill_count <= r_fill_count + 1'b1;
      end
      // Follows the stored valid bits, so it rises one clock after the completing write.
      r_line_valid <= w_fill_start ? 1'b0 : (&r_valid);
    end
  end

  icache_line_ram #(
    .DATA_W   (DATA_W),
    .OFFSET_W (OFFSET_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (cache_wren),
    .i_wr_addr (cache_wroffset),
    .i_wr_data (rom_data),
    .i_rd_addr (cache_rdoffset),
    .o_rd_data (w_ram_q)
  );

  // The RAM read register has no reset, so the word is held at zero until the first read after reset.
  assign instr       = r_rd_live ? w_ram_q : '0;
  assign instr_valid = r_instr_valid;
  assign line_valid  = r_line_valid;
  assign line_tag    = r_line_tag;
  assign fill_count  = r_fill_count;
  assign fill_error  = r_fill_error;

endmodule
